sort_mem_host: RTL and testbench
================================

SORT_MEM_HOST -- requirements
Module: sort_mem_host

Interface
REQ-001 The module SHALL have port clk, input, 1, single clock; all state changes on the rising edge.
REQ-002 The module SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-003 The module SHALL have port in_valid / in_data, input, 1 / 8, load stream carrying the 16 source bytes.
REQ-004 The module SHALL have port in_ready, output, 1, high only in LOAD.
REQ-005 The module SHALL have port sort_en, output, 1, high only in RUN; holds the sorter out of reset.
REQ-006 The module SHALL have port IROM_rd / IROM_A, input, 1 / 4, sorter read request and read address.
REQ-007 The module SHALL have port IROM_Q, output, 8, registered read data.
REQ-008 The module SHALL have port IRAM_valid / IRAM_A / IRAM_D, input, 1 / 4 / 8, sorter write strobe, address and data.
REQ-009 The module SHALL have port done, input, 1, sorter completion flag.
REQ-010 The module SHALL have port out_valid / out_data, output, 1 / 8, result stream, address order 0..15.
REQ-011 The module SHALL have port out_ready, input, 1, result-stream backpressure.

Function
REQ-012 The module SHALL hold two 16x8 arrays: SRC (served on IROM_*) and DST (written via IRAM_*).
REQ-013 The FSM SHALL use states LOAD, RUN, DUMP; transitions LOAD->RUN, RUN->DUMP, DUMP->LOAD, with no other transitions.
REQ-014 In LOAD, each cycle with in_valid&in_ready SHALL write in_data to SRC[ld_cnt] and increment ld_cnt.
REQ-015 The 16th accepted byte (ld_cnt=15) SHALL wrap ld_cnt to 0 and move to RUN next cycle.
REQ-016 On entry to RUN, DST SHALL be cleared to 0x00 and a 5-bit wr_cnt SHALL be cleared.
REQ-017 In RUN, a cycle with IROM_rd=1 SHALL load IROM_Q<=SRC[IROM_A], visible the following cycle (latency 1).
REQ-018 With IROM_rd=0, or outside RUN, IROM_Q SHALL hold its value.
REQ-019 In RUN, IRAM_valid=1 SHALL write DST[IRAM_A]<=IRAM_D and increment wr_cnt (saturating at 31).
REQ-020 IRAM writes outside RUN SHALL be ignored.
REQ-021 Repeated writes to one address SHALL keep the last value.
REQ-022 A write in the same cycle as done's rising edge SHALL still be committed.
REQ-023 The rising edge of done (registered done_d) in RUN SHALL move the FSM to DUMP next cycle and deassert sort_en.
REQ-024 If done is already high on RUN entry, no edge exists, so the FSM SHALL remain in RUN.
REQ-025 In DUMP, out_valid=1 and out_data=DST[rd_cnt]; on out_valid&out_ready rd_cnt increments.
REQ-026 With out_ready=0, out_data SHALL remain stable.
REQ-027 The 16th transfer SHALL drop out_valid, wrap rd_cnt to 0 and return the FSM to LOAD.
REQ-028 The module SHALL deassert in_ready outside LOAD; in_valid outside LOAD SHALL be ignored and no byte lost or stored.
REQ-029 All counters SHALL be 4-bit except wr_cnt; address wrap is natural modulo 16.

Reset
REQ-030 Asserting reset (low), at any time, SHALL immediately force state=LOAD, ld_cnt=rd_cnt=wr_cnt=0, done_d=0.
REQ-031 Asserting reset (low) SHALL immediately force in_ready=0, sort_en=0, out_valid=0, out_data=0x00, IROM_Q=0x00, and SRC=DST=0x00.
REQ-032 in_ready SHALL rise on the first clock edge after reset deasserts.
REQ-033 A reset in RUN or DUMP SHALL abandon the operation; the next load starts at address 0.

Structure
REQ-034 Package sort_pkg SHALL hold DEPTH=16, DATA_W=8, ADDR_W=4 and the state enum {LOAD,RUN,DUMP}.
REQ-035 SRC and DST SHALL each be an instance of one sub-module sort_mem_bank: 16x8 registers, one synchronous write port, one combinational read port, async clear, and a synchronous clear input used for DST on RUN entry.

Verification
REQ-036 Load test: after reset, push 0x10..0x1F -> in_ready=1 for 16 accepts, then sort_en=1 on the next cycle, with SRC[k]=0x10+k.
REQ-037 Read latency test: in RUN, IROM_rd=1, IROM_A=5 at cycle n -> IROM_Q=0x15 at n+1; hold IROM_rd=0 -> IROM_Q stays 0x15.
REQ-038 Write/dump test: write DST[3]=0xAA then DST[3]=0x55, pulse done, out_ready=1 -> 16 beats, beat 3 = 0x55, other beats 0x00, then in_ready=1.
REQ-039 Backpressure test: out_ready toggled 1,0,0,1 during DUMP -> data stable across stalls, no beat dropped or duplicated, exactly 16 transfers.
REQ-040 Boundary test: IRAM_valid with done rising in the same cycle -> write present in the dump; IRAM_valid during LOAD -> DST unchanged.
REQ-041 Reset test: assert reset mid-DUMP after 7 beats -> out_valid=0 immediately; a reload plus RUN cycle produces the full 16-beat dump from address 0.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared sizes and FSM state encoding for the sort memory host.
package sort_pkg;
    localparam int DEPTH  = 16;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DUMP = 2'd2
    } state_t;
endpackage

// File: rtl/sort_mem_bank.sv
// 16x8 register bank: one synchronous write port, one combinational read port,
// asynchronous clear on reset and a synchronous whole-bank clear.
module sort_mem_bank
    import sort_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_r [DEPTH];

    // Storage update: clear has priority over the write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];
endmodule

// File: rtl/sort_mem_host.sv
// Host wrapper for an external sorter: loads 16 source bytes, serves them on
// IROM_*, collects results on IRAM_*, then streams the result array back out.
module sort_mem_host
    import sort_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              sort_en,
    input  logic              IROM_rd,
    input  logic [ADDR_W-1:0] IROM_A,
    output logic [DATA_W-1:0] IROM_Q,
    input  logic              IRAM_valid,
    input  logic [ADDR_W-1:0] IRAM_A,
    input  logic [DATA_W-1:0] IRAM_D,
    input  logic              done,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);
    state_t            state_r;
    logic [ADDR_W-1:0] ld_cnt_r;
    logic [ADDR_W-1:0] rd_cnt_r;
    logic [4:0]        wr_cnt_r;
    logic              done_d_r;
    logic              in_ready_r;
    logic              sort_en_r;
    logic              out_valid_r;
    logic [DATA_W-1:0] out_data_r;
    logic [DATA_W-1:0] irom_q_r;

    logic              accept_s;
    logic              beat_s;
    logic              done_rise_s;
    logic              dst_we_s;
    logic              dst_clr_s;
    logic [ADDR_W-1:0] dst_raddr_s;
    logic [DATA_W-1:0] src_rdata_s;
    logic [DATA_W-1:0] dst_rdata_s;

    assign accept_s    = in_valid & in_ready_r;
    assign beat_s      = out_valid_r & out_ready;
    assign done_rise_s = done & ~done_d_r;
    assign dst_we_s    = (state_r == RUN) & IRAM_valid;
    assign dst_clr_s   = accept_s & (ld_cnt_r == 4'd15);

    // DST read address: word 0 while entering DUMP, next word while streaming.
    always_comb begin
        dst_raddr_s = 4'd0;
        if (state_r == DUMP) begin
            dst_raddr_s = rd_cnt_r + 4'd1;
        end else begin
            dst_raddr_s = 4'd0;
        end
    end

    sort_mem_bank u_src (
        .clk   (clk),
        .rst_n (reset),
        .clr   (1'b0),
        .we    (accept_s),
        .waddr (ld_cnt_r),
        .wdata (in_data),
        .raddr (IROM_A),
        .rdata (src_rdata_s)
    );

    sort_mem_bank u_dst (
        .clk   (clk),
        .rst_n (reset),
        .clr   (dst_clr_s),
        .we    (dst_we_s),
        .waddr (IRAM_A),
        .wdata (IRAM_D),
        .raddr (dst_raddr_s),
        .rdata (dst_rdata_s)
    );

    // Control FSM with registered handshake, enable and data outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= LOAD;
            ld_cnt_r    <= 4'd0;
            rd_cnt_r    <= 4'd0;
            wr_cnt_r    <= 5'd0;
            done_d_r    <= 1'b0;
            in_ready_r  <= 1'b0;
            sort_en_r   <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= 8'h00;
            irom_q_r    <= 8'h00;
        end else begin
            done_d_r <= done;
            case (state_r)
                LOAD: begin
                    if (dst_clr_s) begin
                        state_r    <= RUN;
                        in_ready_r <= 1'b0;
                        sort_en_r  <= 1'b1;
                        wr_cnt_r   <= 5'd0;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                    if (accept_s) begin
                        ld_cnt_r <= ld_cnt_r + 4'd1;
                    end
                end
                RUN: begin
                    if (IROM_rd) begin
                        irom_q_r <= src_rdata_s;
                    end
                    if (dst_we_s && (wr_cnt_r != 5'd31)) begin
                        wr_cnt_r <= wr_cnt_r + 5'd1;
                    end
                    // A write landing with done's edge must reach the first beat.
                    if (done_rise_s) begin
                        state_r     <= DUMP;
                        sort_en_r   <= 1'b0;
                        out_valid_r <= 1'b1;
                        out_data_r  <= (IRAM_valid && (IRAM_A == 4'd0)) ? IRAM_D : dst_rdata_s;
                    end
                end
                DUMP: begin
                    if (beat_s) begin
                        rd_cnt_r <= rd_cnt_r + 4'd1;
                        if (rd_cnt_r == 4'd15) begin
                            state_r     <= LOAD;
                            out_valid_r <= 1'b0;
                            in_ready_r  <= 1'b1;
                            out_data_r  <= 8'h00;
                        end else begin
                            out_data_r <= dst_rdata_s;
                        end
                    end
                end
                default: begin
                    state_r     <= LOAD;
                    in_ready_r  <= 1'b0;
                    sort_en_r   <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign sort_en   = sort_en_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign IROM_Q    = irom_q_r;
endmodule

// File: tb/tb_sort_mem_host.sv
// Scoreboard bench for sort_mem_host: expected dump bytes are queued when the
// sorter finishes and compared beat by beat as the result stream drains.
module tb_sort_mem_host;
    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       sort_en;
    logic       IROM_rd;
    logic [3:0] IROM_A;
    logic [7:0] IROM_Q;
    logic       IRAM_valid;
    logic [3:0] IRAM_A;
    logic [7:0] IRAM_D;
    logic       done;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;

    int         n_total = 0;
    int         n_bad   = 0;
    logic [7:0] src_m [16];
    logic [7:0] dst_m [16];
    logic [7:0] exp_q [$];

    sort_mem_host dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .sort_en    (sort_en),
        .IROM_rd    (IROM_rd),
        .IROM_A     (IROM_A),
        .IROM_Q     (IROM_Q),
        .IRAM_valid (IRAM_valid),
        .IRAM_A     (IRAM_A),
        .IRAM_D     (IRAM_D),
        .done       (done),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] base);
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1;
            in_data  = base + 8'(k);
            check("in_ready_load", {15'd0, in_ready}, 16'd1);
            tick();
            src_m[k] = base + 8'(k);
        end
        in_valid = 1'b0;
        for (int k = 0; k < 16; k++) dst_m[k] = 8'h00;
        check("sort_en_after_load", {15'd0, sort_en}, 16'd1);
        check("in_ready_in_run", {15'd0, in_ready}, 16'd0);
    endtask

    task automatic irom_read(input logic [3:0] a);
        IROM_rd = 1'b1;
        IROM_A  = a;
        tick();
        IROM_rd = 1'b0;
        IROM_A  = ~a;
        check("irom_q", {8'd0, IROM_Q}, {8'd0, src_m[a]});
        tick();
        check("irom_hold", {8'd0, IROM_Q}, {8'd0, src_m[a]});
    endtask

    task automatic iram_write(input logic [3:0] a, input logic [7:0] d, input bit commit);
        IRAM_valid = 1'b1;
        IRAM_A     = a;
        IRAM_D     = d;
        tick();
        IRAM_valid = 1'b0;
        if (commit) dst_m[a] = d;
    endtask

    task automatic end_run(input bit wr, input logic [3:0] a, input logic [7:0] d);
        done       = 1'b1;
        IRAM_valid = wr;
        IRAM_A     = a;
        IRAM_D     = d;
        tick();
        done       = 1'b0;
        IRAM_valid = 1'b0;
        if (wr) dst_m[a] = d;
        check("dump_entry_valid", {15'd0, out_valid}, 16'd1);
        check("dump_entry_sort_en", {15'd0, sort_en}, 16'd0);
        for (int k = 0; k < 16; k++) exp_q.push_back(dst_m[k]);
    endtask

    task automatic dump(input logic [3:0] pat, input int max_beats, input bit stray_wr);
        int         beats   = 0;
        bit         stalled = 1'b0;
        logic [7:0] prev    = 8'h00;
        logic [7:0] exp_b;
        for (int c = 0; c < 100 && beats < max_beats; c++) begin
            out_ready = pat[c % 4];
            check("dump_valid", {15'd0, out_valid}, 16'd1);
            if (stalled) check("stall_stable", {8'd0, out_data}, {8'd0, prev});
            if (out_ready) begin
                exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
                check("beat", {8'd0, out_data}, {8'd0, exp_b});
                beats++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                prev    = out_data;
                if (stray_wr) begin
                    IRAM_valid = 1'b1;
                    IRAM_A     = 4'(beats + 1);
                    IRAM_D     = 8'hEE;
                end
            end
            tick();
            IRAM_valid = 1'b0;
        end
        out_ready = 1'b0;
        check("dump_beats", 16'(beats), 16'(max_beats));
    endtask

    initial begin
        reset      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        IROM_rd    = 1'b0;
        IROM_A     = 4'd0;
        IRAM_valid = 1'b0;
        IRAM_A     = 4'd0;
        IRAM_D     = 8'h00;
        done       = 1'b0;
        out_ready  = 1'b0;
        for (int k = 0; k < 16; k++) begin
            src_m[k] = 8'h00;
            dst_m[k] = 8'h00;
        end

        // Reset state
        tick();
        tick();
        check("rst_in_ready", {15'd0, in_ready}, 16'd0);
        check("rst_sort_en", {15'd0, sort_en}, 16'd0);
        check("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check("rst_out_data", {8'd0, out_data}, 16'h0000);
        check("rst_irom_q", {8'd0, IROM_Q}, 16'h0000);
        reset = 1'b1;
        check("rel_in_ready_low", {15'd0, in_ready}, 16'd0);
        tick();
        check("rel_in_ready_rise", {15'd0, in_ready}, 16'd1);

        // Load, stray input during RUN, read latency and hold
        do_load(8'h10);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        tick();
        in_valid = 1'b0;
        check("in_ready_run_stray", {15'd0, in_ready}, 16'd0);
        irom_read(4'd5);
        irom_read(4'd0);
        irom_read(4'd15);

        // Overwrite then full-speed dump
        iram_write(4'd3, 8'hAA, 1'b1);
        iram_write(4'd3, 8'h55, 1'b1);
        end_run(1'b0, 4'd0, 8'h00);
        dump(4'b1111, 16, 1'b0);
        check("after_dump_valid", {15'd0, out_valid}, 16'd0);
        check("after_dump_in_ready", {15'd0, in_ready}, 16'd1);

        // done already high on RUN entry, write with done's edge, backpressure
        iram_write(4'd7, 8'h77, 1'b0);
        done = 1'b1;
        do_load(8'h40);
        tick();
        tick();
        tick();
        check("done_high_stay_run", {15'd0, sort_en}, 16'd1);
        check("done_high_no_dump", {15'd0, out_valid}, 16'd0);
        done = 1'b0;
        tick();
        iram_write(4'd15, 8'h5A, 1'b1);
        iram_write(4'd9, 8'h33, 1'b1);
        irom_read(4'd0);
        end_run(1'b1, 4'd0, 8'h99);
        dump(4'b1001, 16, 1'b1);
        check("bp_end_valid", {15'd0, out_valid}, 16'd0);
        check("bp_end_in_ready", {15'd0, in_ready}, 16'd1);

        // Reset mid-dump, then a full cycle from address 0
        do_load(8'h60);
        iram_write(4'd4, 8'h44, 1'b1);
        end_run(1'b0, 4'd0, 8'h00);
        dump(4'b1111, 7, 1'b0);
        reset = 1'b0;
        #1;
        check("mid_rst_out_valid", {15'd0, out_valid}, 16'd0);
        check("mid_rst_out_data", {8'd0, out_data}, 16'h0000);
        check("mid_rst_sort_en", {15'd0, sort_en}, 16'd0);
        exp_q.delete();
        for (int k = 0; k < 16; k++) begin
            src_m[k] = 8'h00;
            dst_m[k] = 8'h00;
        end
        tick();
        reset = 1'b1;
        tick();
        check("rst2_in_ready", {15'd0, in_ready}, 16'd1);
        do_load(8'h80);
        irom_read(4'd0);
        iram_write(4'd2, 8'h22, 1'b1);
        end_run(1'b0, 4'd0, 8'h00);
        dump(4'b1111, 16, 1'b0);
        check("final_in_ready", {15'd0, in_ready}, 16'd1);
        check("final_queue_empty", 16'(exp_q.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
